// File: rtl/mem_lsu.sv
// mem_lsu: byte-addressed load/store initiator in front of a 64-bit,
// word-addressed data RAM. Sub-doubleword stores are done as
// read-modify-write. Loads extract byte lanes and sign- or zero-extend them.
// Each request gets exactly one response, with an error flag.
//
// Optional feature macro: MEM_LSU_MISALIGN_SPLIT_EN
//   defined   - doubleword-crossing accesses are split over two RAM words
//               (RD1/WR1 states, second window word w1).
//   undefined - doubleword-crossing accesses are reported as errors and never
//               touch the RAM.
//
// Handshakes: a request transfers on a rising edge where req_valid_i and
// req_ready_o are both high. A response stays valid, with stable data and
// error, until the rising edge where resp_valid_o and resp_ready_i are both
// high.
module mem_lsu #(
    parameter int DATA_WIDTH = 64,
    parameter int RAM_SIZE   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [RAM_SIZE+2:0]   req_addr_i,
    input  logic [2:0]            req_wid_i,
    input  logic [DATA_WIDTH-1:0] req_data_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [DATA_WIDTH-1:0] resp_data_o,
    output logic                  resp_err_o,
    output logic [RAM_SIZE-1:0]   ram_raddr_o,
    output logic [RAM_SIZE-1:0]   ram_waddr_o,
    output logic                  ram_read_o,
    output logic                  ram_write_o,
    output logic [2:0]            ram_wid_o,
    output logic [DATA_WIDTH-1:0] ram_data_o,
    input  logic [DATA_WIDTH-1:0] ram_data_i
);

    localparam int DW = DATA_WIDTH;
`ifdef MEM_LSU_MISALIGN_SPLIT_EN
    localparam int WW = 2 * DW;
`else
    localparam int WW = DW;
`endif
    localparam logic [RAM_SIZE-1:0] ONE = RAM_SIZE'(1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD0  = 3'd1,
        S_RD1  = 3'd2,
        S_WR0  = 3'd3,
        S_WR1  = 3'd4,
        S_RESP = 3'd5
    } state_t;

    state_t              state_q;
    logic                we_q;
    logic [2:0]          off_q;
    logic [2:0]          wid_q;
    logic [RAM_SIZE-1:0] idx_q;
    logic [DW-1:0]       data_q;
`ifdef MEM_LSU_MISALIGN_SPLIT_EN
    logic                split_q;
    logic [DW-1:0]       w0_q;
    logic [DW-1:0]       w1_q;
`endif

    logic [RAM_SIZE-1:0] req_idx;
    logic                req_cross;
    logic                req_err;
    logic                req_aligned_d_store;
    logic [WW-1:0]       win_now;
    logic [WW-1:0]       merged_now;
    logic [DW-1:0]       load_now;

    // Access size in bytes for a width code; the unsigned codes share sizes.
    function automatic logic [3:0] size_of(input logic [2:0] wid);
        case (wid[1:0])
            2'd0:    size_of = 4'd1;
            2'd1:    size_of = 4'd2;
            2'd2:    size_of = 4'd4;
            default: size_of = 4'd8;
        endcase
    endfunction

    function automatic logic [DW-1:0] lane_mask(input logic [2:0] wid);
        case (wid[1:0])
            2'd0:    lane_mask = 64'h0000_0000_0000_00FF;
            2'd1:    lane_mask = 64'h0000_0000_0000_FFFF;
            2'd2:    lane_mask = 64'h0000_0000_FFFF_FFFF;
            default: lane_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    // Shift the window down to the byte offset, keep size bytes, then extend.
    function automatic logic [DW-1:0] load_extract(input logic [WW-1:0] win,
                                                   input logic [2:0]    off,
                                                   input logic [2:0]    wid);
        logic [WW-1:0] sh;
        logic [DW-1:0] s;
        sh = win >> {off, 3'b000};
        s  = sh[DW-1:0];
        case (wid)
            3'd0:    load_extract = {{56{s[7]}}, s[7:0]};
            3'd1:    load_extract = {{48{s[15]}}, s[15:0]};
            3'd2:    load_extract = {{32{s[31]}}, s[31:0]};
            3'd4:    load_extract = {56'd0, s[7:0]};
            3'd5:    load_extract = {48'd0, s[15:0]};
            3'd6:    load_extract = {32'd0, s[31:0]};
            default: load_extract = s;
        endcase
    endfunction

    // Replace bytes off..off+size-1 of the window with the right-aligned store data.
    function automatic logic [WW-1:0] store_merge(input logic [WW-1:0] win,
                                                  input logic [2:0]    off,
                                                  input logic [2:0]    wid,
                                                  input logic [DW-1:0] data);
        logic [WW-1:0] m;
        logic [WW-1:0] d;
        m = WW'(lane_mask(wid)) << {off, 3'b000};
        d = WW'(data & lane_mask(wid)) << {off, 3'b000};
        store_merge = (win & ~m) | d;
    endfunction

    assign req_idx             = req_addr_i[RAM_SIZE+2:3];
    assign req_cross           = ({1'b0, req_addr_i[2:0]} + size_of(req_wid_i)) > 4'd8;
    assign req_aligned_d_store = req_we_i && (req_wid_i == 3'd3) && (req_addr_i[2:0] == 3'd0);
    assign req_ready_o         = (state_q == S_IDLE) && !rst;
    assign ram_wid_o           = 3'd3;

    // Classify the incoming request: bad width codes, and crossings when splitting is off.
    always_comb begin
        req_err = (req_wid_i == 3'd7) || (req_we_i && req_wid_i[2]);
`ifndef MEM_LSU_MISALIGN_SPLIT_EN
        req_err = req_err || req_cross;
`endif
    end

    // Window seen at the end of a read state: fresh RAM data plus any word already captured.
    always_comb begin
`ifdef MEM_LSU_MISALIGN_SPLIT_EN
        win_now = (state_q == S_RD1) ? {ram_data_i, w0_q} : {{DW{1'b0}}, ram_data_i};
`else
        win_now = ram_data_i;
`endif
    end

    assign merged_now = store_merge(win_now, off_q, wid_q, data_q);
    assign load_now   = load_extract(win_now, off_q, wid_q);

    // Control FSM; every RAM and response output is registered here.
    // In non-write states the write address is kept at raddr^1, so the RAM's
    // raddr==waddr forwarding path is never hit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            we_q         <= 1'b0;
            off_q        <= 3'd0;
            wid_q        <= 3'd0;
            idx_q        <= '0;
            data_q       <= '0;
`ifdef MEM_LSU_MISALIGN_SPLIT_EN
            split_q      <= 1'b0;
            w0_q         <= '0;
            w1_q         <= '0;
`endif
            resp_valid_o <= 1'b0;
            resp_err_o   <= 1'b0;
            resp_data_o  <= '0;
            ram_read_o   <= 1'b0;
            ram_write_o  <= 1'b0;
            ram_raddr_o  <= '0;
            ram_waddr_o  <= '0;
            ram_data_o   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid_i) begin
                        we_q   <= req_we_i;
                        off_q  <= req_addr_i[2:0];
                        wid_q  <= req_wid_i;
                        idx_q  <= req_idx;
                        data_q <= req_data_i;
`ifdef MEM_LSU_MISALIGN_SPLIT_EN
                        split_q <= req_cross;
`endif
                        if (req_err) begin
                            state_q      <= S_RESP;
                            resp_valid_o <= 1'b1;
                            resp_err_o   <= 1'b1;
                            resp_data_o  <= '0;
                            ram_waddr_o  <= ram_raddr_o ^ ONE;
                        end else if (req_aligned_d_store) begin
                            state_q     <= S_WR0;
                            ram_write_o <= 1'b1;
                            ram_waddr_o <= req_idx;
                            ram_raddr_o <= req_idx ^ ONE;
                            ram_data_o  <= req_data_i;
                        end else begin
                            state_q     <= S_RD0;
                            ram_read_o  <= 1'b1;
                            ram_raddr_o <= req_idx;
                            ram_waddr_o <= req_idx ^ ONE;
                        end
                    end
                end
                S_RD0: begin
`ifdef MEM_LSU_MISALIGN_SPLIT_EN
                    w0_q <= ram_data_i;
                    if (split_q) begin
                        state_q     <= S_RD1;
                        ram_raddr_o <= idx_q + ONE;
                        ram_waddr_o <= (idx_q + ONE) ^ ONE;
                    end else
`endif
                    if (!we_q) begin
                        state_q      <= S_RESP;
                        ram_read_o   <= 1'b0;
                        resp_valid_o <= 1'b1;
                        resp_err_o   <= 1'b0;
                        resp_data_o  <= load_now;
                    end else begin
                        state_q     <= S_WR0;
                        ram_read_o  <= 1'b0;
                        ram_write_o <= 1'b1;
                        ram_waddr_o <= idx_q;
                        ram_raddr_o <= idx_q ^ ONE;
                        ram_data_o  <= merged_now[DW-1:0];
                    end
                end
`ifdef MEM_LSU_MISALIGN_SPLIT_EN
                S_RD1: begin
                    ram_read_o <= 1'b0;
                    if (!we_q) begin
                        state_q      <= S_RESP;
                        resp_valid_o <= 1'b1;
                        resp_err_o   <= 1'b0;
                        resp_data_o  <= load_now;
                    end else begin
                        // w1 now holds the merged high word for WR1
                        state_q     <= S_WR0;
                        w1_q        <= merged_now[WW-1:DW];
                        ram_write_o <= 1'b1;
                        ram_waddr_o <= idx_q;
                        ram_raddr_o <= idx_q ^ ONE;
                        ram_data_o  <= merged_now[DW-1:0];
                    end
                end
`endif
                S_WR0: begin
`ifdef MEM_LSU_MISALIGN_SPLIT_EN
                    if (split_q) begin
                        state_q     <= S_WR1;
                        ram_waddr_o <= idx_q + ONE;
                        ram_raddr_o <= (idx_q + ONE) ^ ONE;
                        ram_data_o  <= w1_q;
                    end else
`endif
                    begin
                        state_q      <= S_RESP;
                        ram_write_o  <= 1'b0;
                        ram_waddr_o  <= ram_raddr_o ^ ONE;
                        resp_valid_o <= 1'b1;
                        resp_err_o   <= 1'b0;
                        resp_data_o  <= '0;
                    end
                end
`ifdef MEM_LSU_MISALIGN_SPLIT_EN
                S_WR1: begin
                    state_q      <= S_RESP;
                    ram_write_o  <= 1'b0;
                    ram_waddr_o  <= ram_raddr_o ^ ONE;
                    resp_valid_o <= 1'b1;
                    resp_err_o   <= 1'b0;
                    resp_data_o  <= '0;
                end
`endif
                S_RESP: begin
                    if (resp_ready_i) begin
                        state_q      <= S_IDLE;
                        resp_valid_o <= 1'b0;
                        resp_err_o   <= 1'b0;
                        resp_data_o  <= '0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Load/store initiator that sits between the execute stage and the 64-bit word-addressed data RAM. It accepts one byte-addressed load or store per handshake and issues the required full-doubleword RAM reads and writes. It performs read-modify-write for sub-doubleword stores and byte-lane extraction with sign/zero extension for loads. It returns one response per request, flagging illegal or misaligned accesses.

## Interface
- DATA_WIDTH, 64, data path width; only 64 is supported.
- RAM_SIZE, 16, RAM word-address width; the byte address is RAM_SIZE+3 bits.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when high together with req_valid_i.
- req_we_i  in  1  1 = store, 0 = load.
- req_addr_i  in  RAM_SIZE+3  byte address.
- req_wid_i  in  3  width code: B=0, H=1, W=2, D=3, BU=4, HU=5, WU=6.
- req_data_i  in  64  store data, right-aligned.
- resp_valid_o  out  1  response valid; held until resp_ready_i.
- resp_ready_i  in  1  response consumed.
- resp_data_o  out  64  extended load data; 0 for stores and errors.
- resp_err_o  out  1  access error.
- ram_raddr_o, ram_waddr_o  out  RAM_SIZE  RAM word addresses.
- ram_read_o, ram_write_o  out  1  RAM strobes.
- ram_wid_o  out  3  always 3 (D).
- ram_data_o  out  64  RAM write data.
- ram_data_i  in  64  RAM read data; combinational from ram_raddr_o.

## Operation
- Request fields are registered on handshake. The word index is addr[RAM_SIZE+2:3], the byte offset is addr[2:0], and the size is 1, 2, 4 or 8 bytes.
- Error cases: wid = 7, and stores with wid 4–6. These do not access the RAM and go IDLE→RESP with resp_err_o = 1.
- An access crosses a doubleword when offset + size > 8. Handling is covered under Configuration.
- States:
  - IDLE → RD0 for a load, or for a store with size < 8.
  - IDLE → WR0 for an aligned D store.
  - RD0 → RD1 if split; otherwise → RESP for a load, or → WR0 for a store.
  - RD1 → RESP for a load, or → WR0 for a store.
  - WR0 → WR1 if split; otherwise → RESP.
  - WR1 → RESP.
  - RESP → IDLE when resp_ready_i is high.
- RD0/RD1 capture ram_data_i into word registers w0/w1 at the end of the state. ram_read_o is 1 and ram_raddr_o is the word index (RD1: index+1, modulo 2^RAM_SIZE; the top word wraps to 0).
- The RAM forwards data_i whenever its raddr equals its waddr. Therefore in every non-write state, ram_waddr_o = ram_raddr_o ^ 1 and ram_write_o = 0.
- Store merge: the {w1,w0} 128-bit window has bytes offset..offset+size-1 replaced by req_data_i[8*size-1:0]. WR0 writes the low 64 bits to the word index; WR1 writes the high 64 bits to index+1. ram_write_o is 1 only in WR0/WR1. ram_raddr_o = ram_waddr_o ^ 1 during writes and ram_read_o = 0.
- Load data: take ({w1,w0} >> 8*offset)[8*size-1:0], then sign-extend for B/H/W or zero-extend for BU/HU/WU/D.
- req_ready_o = (state == IDLE) & ~rst.

## Timing
- Reset: state IDLE. resp_valid_o, resp_err_o, resp_data_o, ram_read_o, ram_write_o, ram_data_o and the addresses are all 0. A reset mid-operation abandons the request and issues no further write; a write already clocked in WR0 stays committed.
- Latency is counted from the handshake edge T to the first cycle of resp_valid_o:
  - aligned load: T+2
  - sub-word store: T+3
  - aligned D store: T+2
  - split load: T+3
  - split store: T+5
  - error: T+1
- Back-to-back: the next request is accepted in the IDLE cycle after the RESP handshake, so at most one request is outstanding.
- resp_data_o and resp_err_o are stable while resp_valid_o is high and resp_ready_i is low.

## Configuration
- MEM_LSU_MISALIGN_SPLIT_EN defined: doubleword-crossing accesses execute through RD1/WR1 as above, with no error.
- MEM_LSU_MISALIGN_SPLIT_EN undefined: crossing accesses are errors (IDLE→RESP, resp_err_o = 1, no RAM access). RD1/WR1 and w1 are removed; the window is w0 only.

## Test plan
- Store D 0x1122334455667788 to addr 0x40, then load D from 0x40 → resp_data_o 0x1122334455667788. ram_write_o is high for exactly one cycle with waddr 0x8.
- Store B 0xAB to 0x43 over a word holding 0 → word 8 reads 0x00000000AB000000. Load B from 0x43 → 0xFFFFFFFFFFFFFFAB; load BU → 0xAB.
- Store W 0x80000000 to 0x4C, then load W/WU from 0x4C → 0xFFFFFFFF80000000 / 0x0000000080000000. Bytes 0x48–0x4B are unchanged.
- Load H from 0x47:
  - with the macro: returns bytes 0x47..0x48 and issues RAM reads of words 8 then 9.
  - without the macro: resp_err_o = 1 and ram_read_o never asserts.
- Store with wid = 5 or wid = 7 → resp_err_o = 1 at T+1 with no RAM write. resp_valid_o is held for 3 cycles with resp_ready_i low and the data is stable.
- Assert rst during WR1 of a split store → outputs are 0 immediately, word index+1 is unwritten, and req_ready_o = 1 after release.
